// File: rtl/muldiv_pkg.sv
// muldiv_pkg: operation encodings, FSM states and default width
// shared by the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration
// on the shared {upper, lower} accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             isDiv,
  input  logic [2*WIDTH:0] accIn,
  input  logic [WIDTH:0]   opnd,
  output logic [2*WIDTH:0] accOut
);

  logic [WIDTH:0] upper;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] remSh;
  logic [WIDTH:0] trial;
  logic           fits;

  // Upper half is W+1 bits so the add carry and the
  // shifted remainder never lose their top bit.
  always_comb begin
    upper = accIn[2*WIDTH:WIDTH];
    sum   = accIn[0] ? upper + opnd : upper;
    remSh = {accIn[2*WIDTH-1:WIDTH],
             accIn[WIDTH-1]};
    trial = remSh - opnd;
    fits  = remSh >= opnd;
    if (isDiv) begin
      if (fits)
        accOut = {trial,
                  accIn[WIDTH-2:0], 1'b1};
      else
        accOut = {remSh,
                  accIn[WIDTH-2:0], 1'b0};
    end else begin
      accOut = {1'b0, sum, accIn[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: shared iterative MULT/MULTU/DIV/DIVU engine for HI/LO.
// Define MULDIV_EARLY_OUT_EN to end multiplies once the multiplier is exhausted.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int W = WIDTH;

  state_e         state;
  logic [CNT_W-1:0] cnt;
  logic [2*W:0]   acc;
  logic [2*W:0]   stepAcc;
  logic [W:0]     opnd;
  logic           isDiv;
  logic           xNeg;
  logic           rNeg;
  logic           dzPend;

  logic           isDivIn;
  logic           isSgnIn;
  logic           aNeg;
  logic           bNeg;
  logic [W:0]     magA;
  logic [W:0]     magB;

  logic [2*W-1:0] prod;
  logic [W-1:0]   hiRes;
  logic [W-1:0]   loRes;

  always_comb begin
    isDivIn = 1'b0;
    isSgnIn = 1'b0;
    unique case (op_e'(op))
      OP_MULT:  isSgnIn = 1'b1;
      OP_MULTU: isSgnIn = 1'b0;
      OP_DIV: begin
        isDivIn = 1'b1;
        isSgnIn = 1'b1;
      end
      OP_DIVU:  isDivIn = 1'b1;
    endcase
  end

  // W+1-bit magnitudes keep |most-negative| exact.
  assign aNeg = isSgnIn & a[W-1];
  assign bNeg = isSgnIn & b[W-1];
  assign magA = aNeg ? {(W+1){1'b0}} - {a[W-1], a}
                     : {1'b0, a};
  assign magB = bNeg ? {(W+1){1'b0}} - {b[W-1], b}
                     : {1'b0, b};

  muldiv_step #(
    .WIDTH (W)
  ) uStep (
    .isDiv  (isDiv),
    .accIn  (acc),
    .opnd   (opnd),
    .accOut (stepAcc)
  );

`ifdef MULDIV_EARLY_OUT_EN
  logic [CNT_W-1:0] remCnt;
  logic [W-1:0]     remMask;
  logic             earlyOut;

  assign remCnt   = cnt - CNT_W'(1);
  assign remMask  = (W'(1) << remCnt) - W'(1);
  assign earlyOut = !isDiv && (remCnt != '0) &&
                    ((stepAcc[W-1:0] & remMask) == '0);
`endif

  // Remainder follows the dividend sign, so divide truncates to zero.
  always_comb begin
    prod  = xNeg ? -acc[2*W-1:0] : acc[2*W-1:0];
    hiRes = prod[2*W-1:W];
    loRes = prod[W-1:0];
    if (isDiv) begin
      hiRes = rNeg ? -acc[2*W-1:W] : acc[2*W-1:W];
      loRes = xNeg ? -acc[W-1:0] : acc[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      isDiv    <= 1'b0;
      xNeg     <= 1'b0;
      rNeg     <= 1'b0;
      dzPend   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done   <= 1'b0;
      dzPend <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dzPend) done <= 1'b1;
          if (start) begin
            div_zero <= 1'b0;
            if (isDivIn && b == '0) begin
              div_zero <= 1'b1;
              dzPend   <= 1'b1;
            end else begin
              isDiv <= isDivIn;
              xNeg  <= aNeg ^ bNeg;
              rNeg  <= aNeg;
              acc   <= {{(W+1){1'b0}},
                        isDivIn ? magA[W-1:0]
                                : magB[W-1:0]};
              opnd  <= isDivIn ? magB : magA;
              cnt   <= CNT_W'(W);
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= stepAcc;
          cnt <= cnt - CNT_W'(1);
`ifdef MULDIV_EARLY_OUT_EN
          if (earlyOut) begin
            acc   <= stepAcc >> remCnt;
            cnt   <= '0;
            state <= FIX;
          end else
`endif
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          hi    <= hiRes;
          lo    <= loRes;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
